// File: rtl/prince_ti_pkg.sv
// Shared types and constants for the 2-share PRINCE round controller.
package prince_ti_pkg;

  // RUN and DONE both have bit 0 set; that bit drives the share mux select.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b11
  } ctrl_state_e;

  localparam int unsigned PRINCE_ROUNDS = 12;
  localparam int unsigned PRINCE_MID    = 6;
  localparam int unsigned PRINCE_RW     = $clog2(PRINCE_ROUNDS);

  typedef logic [PRINCE_RW-1:0] round_idx_t;

  // Counter width for a modulo-n counter. Always at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prince_ti_stage_cnt.sv
// Modulo-STAGES counter tracking the TI S-box pipeline position within a round.
module prince_ti_stage_cnt
  import prince_ti_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W = cnt_width(STAGES);
  localparam logic [W-1:0] LAST = W'(STAGES - 1);

  logic [W-1:0] cnt_q;

  // Terminal count is an equality test, so non-power-of-two depths never overflow.
  assign tc = (cnt_q == LAST);

  // Count register: clear wins over enable; wraps to zero after the last stage.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prince_ti_round_ctrl.sv
// Sequencing controller for the 2-share threshold PRINCE datapath: steers the
// state-input mux, gates the state-register load and supplies round/direction.
module prince_ti_round_ctrl
  import prince_ti_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = PRINCE_ROUNDS,
  parameter int unsigned MID_ROUND   = PRINCE_MID,
  parameter int unsigned SBOX_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic                          mux_sel,
  output logic                          state_en,
  output logic [$clog2(NUM_ROUNDS)-1:0] round_idx,
  output logic                          dir,
  output logic                          busy
);

  localparam int unsigned RW = $clog2(NUM_ROUNDS);
  localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS - 1);
  localparam logic [RW-1:0] ROUND_MID  = RW'(MID_ROUND);

  // Elaboration-time legality checks.
  if (NUM_ROUNDS < 2) begin : g_bad_rounds
    $fatal(1, "prince_ti_round_ctrl: NUM_ROUNDS must be >= 2");
  end
  if (MID_ROUND < 1 || MID_ROUND >= NUM_ROUNDS) begin : g_bad_mid
    $fatal(1, "prince_ti_round_ctrl: MID_ROUND must satisfy 1 <= MID_ROUND < NUM_ROUNDS");
  end
  if (SBOX_STAGES < 1) begin : g_bad_stages
    $fatal(1, "prince_ti_round_ctrl: SBOX_STAGES must be >= 1");
  end

  ctrl_state_e   state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          stage_en, stage_clr, stage_tc;

  prince_ti_stage_cnt #(
    .STAGES (SBOX_STAGES)
  ) u_stage_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stage_en),
    .clr (stage_clr),
    .tc  (stage_tc)
  );

  // The select comes straight off a state flop so both share instances see a
  // glitch-free, cycle-stable value.
  assign mux_sel   = state_q[0];
  assign round_idx = round_q;
  // Round counter is zero outside RUN, so dir is low there as MID_ROUND >= 1.
  assign dir       = (round_q >= ROUND_MID);

  // State and round registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state, round sequencing and handshake/enable decode.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    stage_en  = 1'b0;
    stage_clr = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    state_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // Fresh shares load on the accepting edge.
        state_en = in_valid;
        if (in_valid) begin
          state_d   = RUN;
          round_d   = '0;
          stage_clr = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        stage_en = 1'b1;
        // Capture feedback only once the S-box pipeline has drained.
        state_en = stage_tc;
        if (stage_tc) begin
          if (round_q == ROUND_LAST) begin
            state_d = DONE;
            round_d = '0;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

endmodule
